// File: rtl/display_scan_if.sv
// Bundle between the game/menu logic and the seven-segment scan driver.
// The master supplies patterns, load strobes and display controls; the
// slave (display_scan) drives the segment/select pins and the frame tick.
interface display_scan_if #(
    parameter int DIGITS = 8,
    parameter int SEG_W  = 7
);
    logic                      enable;
    logic [DIGITS*SEG_W-1:0]   seg_in;
    logic                      load;
    logic [DIGITS-1:0]         blink_mask;
    logic [3:0]                brightness;
    logic [SEG_W-1:0]          displayout;
    logic [DIGITS-1:0]         selector;
    logic                      frame_tick;

    modport master (
        output enable, seg_in, load, blink_mask, brightness,
        input  displayout, selector, frame_tick
    );

    modport slave (
        input  enable, seg_in, load, blink_mask, brightness,
        output displayout, selector, frame_tick
    );
endinterface

// File: rtl/display_scan.sv
// Multiplexed seven-segment scan driver: DIGITS common-select digits, each
// owning a DIV-cycle slot that opens with BLANK dead cycles, followed by a
// brightness-scaled lit window.  Segment data is double buffered and swapped
// only at the frame boundary so a frame never mixes old and new patterns.
module display_scan #(
    parameter int DIGITS         = 8,
    parameter int SEG_W          = 7,
    parameter int DIV            = 1350,
    parameter int BLANK          = 8,
    parameter int BLINK_DIV      = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    display_scan_if.slave  bus
);

    localparam int SLOT_W = $clog2(DIV);
    localparam int DIG_W  = $clog2(DIGITS);
    localparam int FRM_W  = $clog2(BLINK_DIV + 1);
    localparam int ON_W   = SLOT_W + 1;
    localparam int PROD_W = SLOT_W + 5;

    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_S    = SLOT_W'(BLANK);
    localparam logic [DIG_W-1:0]  DIGIT_LAST = DIG_W'(DIGITS - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST   = FRM_W'(BLINK_DIV - 1);
    localparam logic [PROD_W-1:0] LIT_SPAN   = PROD_W'(DIV - BLANK);
    localparam logic [SEG_W-1:0]  SEG_OFF    = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] SEL_OFF    = {DIGITS{SEL_ACTIVE_LOW}};

    // Scan state
    logic [SLOT_W-1:0]         slot_cnt_reg;
    logic [DIG_W-1:0]          digit_reg;
    logic [FRM_W-1:0]          frame_cnt_reg;
    logic                      blink_phase_reg;
    logic [ON_W-1:0]           on_len_reg;

    // Frame buffers
    logic [DIGITS*SEG_W-1:0]   shadow_reg;
    logic [DIGITS*SEG_W-1:0]   active_reg;

    // Registered pin drive
    logic [SEG_W-1:0]          displayout_reg;
    logic [DIGITS-1:0]         selector_reg;
    logic                      frame_tick_reg;

    // Decoded views of the current scan position
    logic [PROD_W-1:0]         on_prod;
    logic [ON_W-1:0]           on_len_new;
    logic [ON_W-1:0]           on_len_cur;
    logic [ON_W-1:0]           slot_rel;
    logic                      in_window;
    logic                      blinked;
    logic                      lit;
    logic                      slot_wrap;
    logic                      frame_end;
    logic [SEG_W-1:0]          digit_seg [DIGITS];
    logic [DIGITS-1:0]         digit_onehot;

    // Per-digit views: active pattern slice and select decode
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_seg[gi]    = active_reg[gi*SEG_W +: SEG_W];
            assign digit_onehot[gi] = (digit_reg == DIG_W'(gi));
        end
    endgenerate

    // Lit length for the slot: product kept at full width so brightness 15
    // yields exactly DIV-BLANK cycles.  At slot 0 the freshly computed value
    // is used directly, so the window is correct even with BLANK = 0.
    assign on_prod    = LIT_SPAN * PROD_W'({1'b0, bus.brightness} + 5'd1);
    assign on_len_new = ON_W'(on_prod >> 4);
    assign on_len_cur = (slot_cnt_reg == '0) ? on_len_new : on_len_reg;

    assign slot_rel   = ON_W'(slot_cnt_reg) - ON_W'(BLANK_S);
    assign in_window  = (slot_cnt_reg >= BLANK_S) && (slot_rel < on_len_cur);
    assign blinked    = blink_phase_reg && bus.blink_mask[digit_reg];
    assign lit        = in_window && !blinked;

    assign slot_wrap  = (slot_cnt_reg == SLOT_LAST);
    assign frame_end  = slot_wrap && (digit_reg == DIGIT_LAST);

    // Slot/digit/frame counters, blink phase and per-slot brightness latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_reg    <= '0;
            digit_reg       <= '0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            on_len_reg      <= '0;
        end else if (!bus.enable) begin
            slot_cnt_reg    <= '0;
            digit_reg       <= '0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            slot_cnt_reg <= slot_wrap ? '0 : slot_cnt_reg + SLOT_W'(1);
            if (slot_wrap) begin
                digit_reg <= (digit_reg == DIGIT_LAST) ? '0 : digit_reg + DIG_W'(1);
            end
            if (frame_end) begin
                if (frame_cnt_reg == FRM_LAST) begin
                    frame_cnt_reg   <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    frame_cnt_reg   <= frame_cnt_reg + FRM_W'(1);
                end
            end
            if (slot_cnt_reg == '0) begin
                on_len_reg <= on_len_new;
            end
        end
    end

    // Shadow loads on any cycle; active swaps only at the frame boundary,
    // taking a coincident load directly so it is not lost for a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg <= '0;
            active_reg <= '0;
        end else begin
            if (bus.load) begin
                shadow_reg <= bus.seg_in;
            end
            if (bus.enable && frame_end) begin
                active_reg <= bus.load ? bus.seg_in : shadow_reg;
            end
        end
    end

    // Registered pin drive derived from the current scan position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selector_reg   <= SEL_OFF;
            displayout_reg <= SEG_OFF;
            frame_tick_reg <= 1'b0;
        end else if (!bus.enable) begin
            selector_reg   <= SEL_OFF;
            displayout_reg <= SEG_OFF;
            frame_tick_reg <= 1'b0;
        end else begin
            selector_reg   <= lit ? (digit_onehot ^ SEL_OFF) : SEL_OFF;
            displayout_reg <= lit ? (digit_seg[digit_reg] ^ SEG_OFF) : SEG_OFF;
            frame_tick_reg <= frame_end;
        end
    end

    assign bus.selector   = selector_reg;
    assign bus.displayout = displayout_reg;
    assign bus.frame_tick = frame_tick_reg;

endmodule

// File: doc/display_scan.md
# display_scan

Parametrised multiplexed seven-segment scan driver, successor to the fixed 8-digit display mux. It scans `DIGITS` common-select digits at a programmable slot length and adds the following:
- dead-time blanking between digits, to suppress ghosting;
- 16-level brightness PWM;
- per-digit blink;
- tear-free double-buffered frame loading.

It sits between the game/menu state logic, which supplies packed segment patterns, and the board's segment/select pins.

## Interface
- `DIGITS`, 8: number of multiplexed digits (≥2).
- `SEG_W`, 7: segment bits per digit.
- `DIV`, 1350: clk cycles per digit slot (≥ `BLANK`+16).
- `BLANK`, 8: dead cycles at the start of each slot, with all selects inactive.
- `BLINK_DIV`, 64: scan frames per blink half-period (≥1).
- `SEG_ACTIVE_LOW`, 1: segment outputs are active-low when 1.
- `SEL_ACTIVE_LOW`, 0: select outputs are active-low when 1.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: scan enable.
- `seg_in` in `DIGITS*SEG_W`: digit i pattern is at `[i*SEG_W +: SEG_W]`; segment bit 1 means lit.
- `load` in 1: capture `seg_in` into the shadow buffer.
- `blink_mask` in `DIGITS`: bit i = 1 makes digit i blink.
- `brightness` in 4: duty in sixteenths; 15 means full.
- `displayout` out `SEG_W`: segment drive, polarity set by `SEG_ACTIVE_LOW`.
- `selector` out `DIGITS`: one-hot digit select, polarity set by `SEL_ACTIVE_LOW`.
- `frame_tick` out 1: one-cycle pulse at the end of each frame.

## Operation
- **Counters:**
  - `slot_cnt` runs 0..`DIV`-1 and wraps.
  - `digit` runs 0..`DIGITS`-1 and advances on each `slot_cnt` wrap.
  - A frame is `DIGITS*DIV` cycles.
- **Frame boundary:** the cycle where `slot_cnt`=`DIV`-1 and `digit`=`DIGITS`-1.
- **Double buffer:**
  - `load`=1 writes `seg_in` into the shadow buffer on any cycle.
  - At the frame boundary, the active buffer takes the shadow value.
  - If `load` coincides with the boundary, the active buffer takes `seg_in` directly.
  - The displayed frame therefore never mixes old and new data.
- **Brightness:**
  - `brightness` is sampled into `on_len` = ((`DIV`-`BLANK`)*(`brightness`+1))>>4 when `slot_cnt`=0.
  - The value is held for the whole slot, so mid-slot changes take effect at the next slot.
- **Lit condition:** `BLANK` ≤ `slot_cnt` < `BLANK`+`on_len`.
  - While lit, `selector` asserts bit `digit` and `displayout` shows active-buffer digit `digit`.
  - Otherwise all selects and all segments are at their inactive level.
- **Blink:**
  - A frame counter toggles `blink_phase` every `BLINK_DIV` frames.
  - When `blink_phase`=1 and `blink_mask[digit]`=1, the slot is treated as dark for the whole slot.
- **Enable:** `enable`=0 holds `slot_cnt`, `digit`, the frame counter and `blink_phase` at 0, and drives outputs inactive. Buffers still load.
- **Mapping:** digit i drives `selector[i]`. Digit 0 maps to display position 0, matching the existing mux's `display0`.

## Timing
- All outputs are registered with one-cycle latency from counter state. The output at cycle t reflects the counters at t-1.
- **Reset values (asynchronous):**
  - counters, `blink_phase`, shadow buffer and active buffer: 0;
  - `frame_tick`: 0;
  - `selector`: all inactive (`{DIGITS{SEL_ACTIVE_LOW}}`);
  - `displayout`: all inactive (`{SEG_W{SEG_ACTIVE_LOW}}`).
- **Reset mid-scan:** outputs go inactive immediately. After release, scanning restarts at digit 0, `slot_cnt` 0.
- **`frame_tick`:** high for the one cycle after the frame-boundary cycle. The newly loaded data is displayed starting at the next digit-0 lit window.
- **After `enable` rises:** first select assertion occurs `BLANK`+1 cycles later.
- **Width:** `on_len` is computed at full width and is never wider than `DIV`-`BLANK`. Brightness 15 gives exactly `DIV`-`BLANK` lit cycles.

## Test plan
Bench configuration: `DIGITS`=4, `DIV`=20, `BLANK`=2, `BLINK_DIV`=2, `SEG_ACTIVE_LOW`=1, `SEL_ACTIVE_LOW`=0.
- **Reset:** hold `rst_n`=0 → `selector`=4'b0000, `displayout`=7'h7F, `frame_tick`=0. Release with `enable`=1, `brightness`=15, and load 28'h0000001 before release is impossible, so load it right after → first frame blank. On the next frame, `selector`=0001 for 18 cycles, `displayout`=7'h7E.
- **Scan order:** load all digits 7'h7F, brightness 15 → `selector` sequence 0001, 0010, 0100, 1000. Each select is high 18 cycles, preceded by 2 dark cycles. `frame_tick` pulses every 80 cycles.
- **Brightness:** `brightness`=7 → `on_len`=9, so 9 lit and 11 dark cycles per slot. Change to 3 mid-slot → current slot stays 9 lit, next slot has 4 lit.
- **Tear-free load:**
  - Load pattern A, then load pattern B in the middle of digit 1 → remaining digits of that frame still show A; B appears from the frame after `frame_tick`.
  - Load coinciding with the boundary → the new value is shown in the next frame.
- **Blink:** `blink_mask`=4'b0010 → digit 1 is lit in frames 0–1, dark in frames 2–3, lit in frames 4–5. Other digits are unaffected. `blink_phase` returns to 0 after `enable` toggles.
- **Enable/reset mid-operation:**
  - Drop `enable` in the middle of digit 2 → outputs are inactive on the next cycle. Re-enable → scan restarts at digit 0 with first select 3 cycles later.
  - Assert `rst_n`=0 mid-slot → outputs are inactive asynchronously and the buffers clear.
